// File: rtl/proc_mem_port_arbiter_pkg.sv
// Shared memory-message types for the 4-byte processor/memory val/rdy interfaces.
package proc_mem_port_arbiter_pkg;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

endpackage

// File: rtl/proc_mem_arb_route_fifo.sv
// In-order queue of 1-bit port IDs; a separate count tells full from empty.
module proc_mem_arb_route_fifo #(
   parameter int p_depth = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq_en,
   input  logic                     enq_data,
   input  logic                     deq_en,
   output logic                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(p_depth):0] count
);

   localparam int AW = $clog2(p_depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);

   logic          mem [p_depth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_enq;
   logic          do_deq;

   assign full   = (cnt == FULL_CNT);
   assign empty  = (cnt == '0);
   assign do_enq = enq_en & ~full;
   assign do_deq = deq_en & ~empty;
   assign head   = mem[rd_ptr];
   assign count  = cnt;

   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= enq_data;
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + AW'(1);
         if (do_deq) rd_ptr <= rd_ptr + AW'(1);
         case ({do_enq, do_deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/proc_mem_port_arbiter.sv
// Round-robin sharing of one memory port between imem and dmem, with
// responses steered back to their requester through an in-order route queue.
module proc_mem_port_arbiter
   import proc_mem_port_arbiter_pkg::*;
#(
   parameter int p_max_inflight = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            imemreq_val,
   output logic                            imemreq_rdy,
   input  mem_req_4B_t                     imemreq_msg,
   input  logic                            dmemreq_val,
   output logic                            dmemreq_rdy,
   input  mem_req_4B_t                     dmemreq_msg,
   output logic                            imemresp_val,
   input  logic                            imemresp_rdy,
   output mem_resp_4B_t                    imemresp_msg,
   output logic                            dmemresp_val,
   input  logic                            dmemresp_rdy,
   output mem_resp_4B_t                    dmemresp_msg,
   output logic                            memreq_val,
   input  logic                            memreq_rdy,
   output mem_req_4B_t                     memreq_msg,
   input  logic                            memresp_val,
   output logic                            memresp_rdy,
   input  mem_resp_4B_t                    memresp_msg,
   output logic [$clog2(p_max_inflight):0] inflight
);

   localparam logic IMEM = 1'b0;
   localparam logic DMEM = 1'b1;

   // val/rdy: a transfer happens in any cycle where both are high; no val
   // output here depends on the rdy of its own channel.

   logic prio;
   logic sel;
   logic any_val;
   logic full;
   logic empty;
   logic head;
   logic req_fire;
   logic resp_fire;

   always_comb begin
      if (imemreq_val && dmemreq_val) sel = prio;
      else if (dmemreq_val)           sel = DMEM;
      else                            sel = IMEM;
   end

   assign any_val     = imemreq_val | dmemreq_val;
   assign memreq_val  = any_val & ~full;
   assign memreq_msg  = !any_val ? '0 : (sel == DMEM) ? dmemreq_msg : imemreq_msg;
   assign imemreq_rdy = (sel == IMEM) & memreq_rdy & ~full;
   assign dmemreq_rdy = (sel == DMEM) & memreq_rdy & ~full;
   assign req_fire    = memreq_val & memreq_rdy;
   assign resp_fire   = memresp_val & memresp_rdy;

   // An empty queue means any response is stray: accept it and drop it.
   always_comb begin
      imemresp_val = 1'b0;
      imemresp_msg = '0;
      dmemresp_val = 1'b0;
      dmemresp_msg = '0;
      memresp_rdy  = 1'b1;
      if (!empty) begin
         if (head == DMEM) begin
            dmemresp_val = memresp_val;
            dmemresp_msg = memresp_msg;
            memresp_rdy  = dmemresp_rdy;
         end else begin
            imemresp_val = memresp_val;
            imemresp_msg = memresp_msg;
            memresp_rdy  = imemresp_rdy;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        prio <= IMEM;
      else if (req_fire) prio <= ~sel;
   end

   proc_mem_arb_route_fifo #(.p_depth(p_max_inflight)) u_route_fifo (
      .clk      (clk),
      .reset    (reset),
      .enq_en   (req_fire),
      .enq_data (sel),
      .deq_en   (resp_fire),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (inflight)
   );

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Bench for proc_mem_port_arbiter: directed vector table, hand sequences and
// random traffic against a queue-based reference model.
module tb_proc_mem_port_arbiter;
   import proc_mem_port_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic         clk;
   logic         reset;
   logic         imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
   mem_req_4B_t  imemreq_msg, dmemreq_msg, memreq_msg;
   logic         imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
   mem_resp_4B_t imemresp_msg, dmemresp_msg, memresp_msg;
   logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
   logic [2:0]   inflight;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: outstanding requester IDs in order, and last port granted.
   bit route_q[$];
   int last_grant;

   proc_mem_port_arbiter #(.p_max_inflight(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_msg(imemreq_msg),
      .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_msg(dmemreq_msg),
      .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_msg(imemresp_msg),
      .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_msg(dmemresp_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic mem_req_4B_t mk_req(input logic [31:0] addr);
      mem_req_4B_t r;
      r.type_  = 3'($urandom);
      r.opaque = 8'($urandom);
      r.addr   = addr;
      r.len    = 2'($urandom);
      r.data   = $urandom;
      return r;
   endfunction

   function automatic mem_resp_4B_t mk_resp();
      mem_resp_4B_t r;
      r.type_  = 3'($urandom);
      r.opaque = 8'($urandom);
      r.test   = 2'($urandom);
      r.len    = 2'($urandom);
      r.data   = $urandom;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic clear_inputs();
      imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
      imemresp_rdy = 0; dmemresp_rdy = 0;
      imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      route_q.delete();
      last_grant = 1;
   endtask

   // Compare every output against the model, then advance the model over the edge.
   task automatic model_cycle(input string tag);
      bit any, full, win, i_fire, o_fire;
      mem_req_4B_t  exp_req;
      full = (route_q.size() == DEPTH);
      any  = imemreq_val | dmemreq_val;
      if (imemreq_val && dmemreq_val) win = (last_grant == 0);
      else                            win = dmemreq_val;
      exp_req = !any ? '0 : (win ? dmemreq_msg : imemreq_msg);
      chk({tag, " memreq_val"}, memreq_val, any & !full);
      chk({tag, " memreq_msg"}, memreq_msg, exp_req);
      if (imemreq_val) chk({tag, " imemreq_rdy"}, imemreq_rdy, !win & memreq_rdy & !full);
      if (dmemreq_val) chk({tag, " dmemreq_rdy"}, dmemreq_rdy, win & memreq_rdy & !full);
      chk({tag, " inflight"}, inflight, route_q.size());
      if (route_q.size() == 0) begin
         chk({tag, " memresp_rdy"}, memresp_rdy, 1);
         chk({tag, " imemresp_val"}, imemresp_val, 0);
         chk({tag, " dmemresp_val"}, dmemresp_val, 0);
         o_fire = memresp_val;
      end else begin
         chk({tag, " memresp_rdy"}, memresp_rdy, route_q[0] ? dmemresp_rdy : imemresp_rdy);
         chk({tag, " imemresp_val"}, imemresp_val, !route_q[0] & memresp_val);
         chk({tag, " dmemresp_val"}, dmemresp_val, route_q[0] & memresp_val);
         chk({tag, " imemresp_msg"}, imemresp_msg, route_q[0] ? '0 : memresp_msg);
         chk({tag, " dmemresp_msg"}, dmemresp_msg, route_q[0] ? memresp_msg : '0);
         o_fire = memresp_val & (route_q[0] ? dmemresp_rdy : imemresp_rdy);
      end
      i_fire = any & !full & memreq_rdy;
      if (o_fire && route_q.size() > 0) void'(route_q.pop_front());
      if (i_fire) begin
         route_q.push_back(win);
         last_grant = int'(win);
      end
   endtask

   typedef struct {
      logic iv, dv, mrdy, rv, irr, drr;
      logic exp_mval, exp_sel;
      logic [1:0] exp_dest;  // 0 none, 1 imem, 2 dmem
      int exp_inflight;
   } vec_t;

   vec_t tbl[14];

   initial begin
      bit exp_full;
      mem_resp_4B_t rsp;

      tbl[0]  = '{1,1,1,0,1,1, 1,0,0,0};
      tbl[1]  = '{1,1,1,0,1,1, 1,1,1,1};
      tbl[2]  = '{1,1,1,0,1,1, 1,0,1,2};
      tbl[3]  = '{1,1,1,0,1,1, 1,1,1,3};
      tbl[4]  = '{1,1,1,1,1,1, 0,0,1,4};
      tbl[5]  = '{1,1,1,0,1,1, 1,0,2,3};
      tbl[6]  = '{0,0,1,1,1,0, 0,0,2,4};
      tbl[7]  = '{0,0,1,1,1,1, 0,0,2,4};
      tbl[8]  = '{0,0,1,1,1,1, 0,0,1,3};
      tbl[9]  = '{0,0,1,1,1,1, 0,0,2,2};
      tbl[10] = '{0,1,0,1,1,1, 1,1,1,1};
      tbl[11] = '{0,1,1,1,1,1, 1,1,0,0};
      tbl[12] = '{1,1,1,1,1,1, 1,0,2,1};
      tbl[13] = '{0,0,1,0,1,1, 0,0,1,1};

      reset_dut();

      // Reset state
      memreq_rdy = 1'b0;
      mid();
      chk("rst inflight", inflight, 0);
      chk("rst memreq_val", memreq_val, 0);
      chk("rst memreq_msg", memreq_msg, 0);
      chk("rst memresp_rdy", memresp_rdy, 1);
      chk("rst imemresp_val", imemresp_val, 0);
      chk("rst dmemresp_val", dmemresp_val, 0);
      chk("rst imemresp_msg", imemresp_msg, 0);
      chk("rst dmemresp_msg", dmemresp_msg, 0);
      chk("rst imemreq_rdy lo", imemreq_rdy, 0);
      memreq_rdy = 1'b1;
      #1;
      chk("rst imemreq_rdy hi", imemreq_rdy, 1);
      step();

      // Directed vector table: contention, full stall, response stall, stray drop.
      for (int i = 0; i < 14; i++) begin
         imemreq_val = tbl[i].iv;  dmemreq_val = tbl[i].dv;
         memreq_rdy  = tbl[i].mrdy; memresp_val = tbl[i].rv;
         imemresp_rdy = tbl[i].irr; dmemresp_rdy = tbl[i].drr;
         imemreq_msg = mk_req(32'h1000 + i);
         dmemreq_msg = mk_req(32'h2000 + i);
         rsp = mk_resp();
         memresp_msg = rsp;
         mid();
         exp_full = (tbl[i].exp_inflight == DEPTH);
         chk($sformatf("vec%0d memreq_val", i), memreq_val, tbl[i].exp_mval);
         chk($sformatf("vec%0d memreq_msg", i), memreq_msg,
             !(tbl[i].iv | tbl[i].dv) ? '0 : (tbl[i].exp_sel ? dmemreq_msg : imemreq_msg));
         if (tbl[i].iv)
            chk($sformatf("vec%0d imemreq_rdy", i), imemreq_rdy, !tbl[i].exp_sel & tbl[i].mrdy & !exp_full);
         if (tbl[i].dv)
            chk($sformatf("vec%0d dmemreq_rdy", i), dmemreq_rdy, tbl[i].exp_sel & tbl[i].mrdy & !exp_full);
         chk($sformatf("vec%0d inflight", i), inflight, tbl[i].exp_inflight);
         chk($sformatf("vec%0d imemresp_val", i), imemresp_val, tbl[i].rv & (tbl[i].exp_dest == 1));
         chk($sformatf("vec%0d dmemresp_val", i), dmemresp_val, tbl[i].rv & (tbl[i].exp_dest == 2));
         chk($sformatf("vec%0d imemresp_msg", i), imemresp_msg, (tbl[i].exp_dest == 1) ? rsp : '0);
         chk($sformatf("vec%0d dmemresp_msg", i), dmemresp_msg, (tbl[i].exp_dest == 2) ? rsp : '0);
         chk($sformatf("vec%0d memresp_rdy", i), memresp_rdy,
             (tbl[i].exp_dest == 0) ? 1'b1 : (tbl[i].exp_dest == 1) ? tbl[i].irr : tbl[i].drr);
         step();
      end

      // One-cycle round trip on imem at 0x200.
      reset_dut();
      imemreq_val = 1; memreq_rdy = 1; imemreq_msg = mk_req(32'h200);
      mid();
      chk("rt addr", memreq_msg.addr, 32'h200);
      chk("rt imemreq_rdy", imemreq_rdy, 1);
      chk("rt inflight0", inflight, 0);
      step();
      clear_inputs();
      memresp_val = 1; imemresp_rdy = 1; memresp_msg = mk_resp();
      mid();
      chk("rt imemresp_val", imemresp_val, 1);
      chk("rt dmemresp_val", dmemresp_val, 0);
      chk("rt inflight1", inflight, 1);
      step();
      clear_inputs();
      mid();
      chk("rt inflight2", inflight, 0);
      step();

      // Random traffic against the reference model.
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         imemreq_val  = ($urandom_range(0, 99) < 60);
         dmemreq_val  = ($urandom_range(0, 99) < 60);
         memreq_rdy   = ($urandom_range(0, 99) < 75);
         memresp_val  = ($urandom_range(0, 99) < 50);
         imemresp_rdy = ($urandom_range(0, 99) < 75);
         dmemresp_rdy = ($urandom_range(0, 99) < 75);
         imemreq_msg  = mk_req($urandom);
         dmemreq_msg  = mk_req($urandom);
         memresp_msg  = mk_resp();
         mid();
         model_cycle($sformatf("rnd%0d", c));
         step();
      end

      // Reset with two requests outstanding; late response must be dropped.
      reset_dut();
      imemreq_val = 1; memreq_rdy = 1; imemreq_msg = mk_req(32'h300);
      step();
      imemreq_val = 0; dmemreq_val = 1; dmemreq_msg = mk_req(32'h400);
      step();
      clear_inputs();
      mid();
      chk("mrst inflight2", inflight, 2);
      reset = 1'b0;
      #1;
      chk("mrst async inflight", inflight, 0);
      step();
      reset = 1'b1;
      memresp_val = 1; imemresp_rdy = 1; dmemresp_rdy = 1; memresp_msg = mk_resp();
      mid();
      chk("mrst imemresp_val", imemresp_val, 0);
      chk("mrst dmemresp_val", dmemresp_val, 0);
      chk("mrst memresp_rdy", memresp_rdy, 1);
      chk("mrst inflight", inflight, 0);
      step();
      clear_inputs();
      imemreq_val = 1; dmemreq_val = 1; memreq_rdy = 1;
      imemreq_msg = mk_req(32'h500); dmemreq_msg = mk_req(32'h600);
      mid();
      chk("mrst grant msg", memreq_msg, imemreq_msg);
      chk("mrst imemreq_rdy", imemreq_rdy, 1);
      chk("mrst dmemreq_rdy", dmemreq_rdy, 0);
      step();
      clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
